// File: rtl/mpeg2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mpeg2_pkg
// Purpose  : Shared constants for the zigzag/RLE stage: zigzag scan table,
//            FSM state encoding and default coefficient/run widths.
// Revision : 1.0  initial release
// ============================================================================
package mpeg2_pkg;

  localparam int CW_DEF = 16;
  localparam int RW_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SCAN  = 2'd2,
    ST_EOB   = 2'd3
  } rle_state_t;

  // Scan index -> raster address (row*8+col), classic zigzag order.
  localparam logic [5:0] ZZ_TABLE [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

endpackage
`default_nettype wire

// File: rtl/zigzag_rom.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_rom
// Purpose  : Combinational zigzag scan index to raster address lookup.
// Revision : 1.0  initial release
// ============================================================================
module zigzag_rom
  import mpeg2_pkg::*;
(
  input  logic [5:0] idx_i,
  output logic [5:0] addr_o
);

  assign addr_o = ZZ_TABLE[idx_i];

endmodule
`default_nettype wire

// File: rtl/zigzag_rle.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_rle
// Purpose  : Zigzag-scans one 8x8 coefficient block and emits (run, level)
//            tokens closed by an EOB token. Optional DC differential coding
//            is enabled with the RLE_DC_DIFF_EN macro.
// Revision : 1.0  initial release
// ============================================================================
module zigzag_rle
  import mpeg2_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          rdy,
  output logic [5:0]    raddr,
  input  logic [CW-1:0] rq,
  input  logic          dc_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_run,
  output logic [CW-1:0] out_level,
  output logic          out_eob
);

  rle_state_t    state_q;
  logic [5:0]    k_q;
  logic [RW-1:0] run_q;
  logic          held_q;
  logic [CW-1:0] hold_q;
  logic          rdy_q;
  logic [5:0]    raddr_q;
  logic          out_valid_q;
  logic [RW-1:0] out_run_q;
  logic [CW-1:0] out_level_q;
  logic          out_eob_q;

  logic [CW-1:0] coef;
  logic [CW-1:0] dc_level;
  logic          out_free;
  logic          is_dc;
  logic          is_last;
  logic          need_emit;
  logic [5:0]    rom_idx;
  logic [5:0]    rom_addr;

  // A stalled coefficient is parked in hold_q because the RAM has already
  // moved on to the next address; raddr is frozen so rq stays on ZZ[k+1].
  assign coef      = held_q ? hold_q : rq;
  assign out_free  = !out_valid_q || out_ready;
  assign is_dc     = (k_q == 6'd0);
  assign is_last   = (k_q == 6'd63);
  assign need_emit = is_dc || (coef != '0);

  always_comb begin
    rom_idx = 6'd0;
    case (state_q)
      ST_IDLE:  rom_idx = 6'd0;
      ST_PRIME: rom_idx = 6'd1;
      default:  rom_idx = (k_q >= 6'd62) ? 6'd63 : k_q + 6'd2;
    endcase
  end

  zigzag_rom u_rom (
    .idx_i  (rom_idx),
    .addr_o (rom_addr)
  );

`ifdef RLE_DC_DIFF_EN
  logic [CW-1:0] dc_pred_q;
  assign dc_level = coef - dc_pred_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc_pred_q <= '0;
    end else if (state_q == ST_IDLE && dc_clr) begin
      dc_pred_q <= '0;
    end else if (state_q == ST_SCAN && is_dc && out_free) begin
      dc_pred_q <= coef;
    end
  end
`else
  logic unused_dc_clr;
  assign unused_dc_clr = dc_clr;
  assign dc_level      = coef;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      k_q         <= 6'd0;
      run_q       <= '0;
      held_q      <= 1'b0;
      hold_q      <= '0;
      rdy_q       <= 1'b1;
      raddr_q     <= 6'd0;
      out_valid_q <= 1'b0;
      out_run_q   <= '0;
      out_level_q <= '0;
      out_eob_q   <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q <= ST_PRIME;
            rdy_q   <= 1'b0;
            k_q     <= 6'd0;
            run_q   <= '0;
            held_q  <= 1'b0;
            raddr_q <= rom_addr;
          end
        end
        ST_PRIME: begin
          state_q <= ST_SCAN;
          raddr_q <= rom_addr;
        end
        ST_SCAN: begin
          if (need_emit && !out_free) begin
            held_q <= 1'b1;
            hold_q <= coef;
          end else begin
            held_q <= 1'b0;
            if (need_emit) begin
              out_valid_q <= 1'b1;
              out_eob_q   <= 1'b0;
              out_run_q   <= run_q;
              out_level_q <= is_dc ? dc_level : coef;
              run_q       <= '0;
            end else if (is_last) begin
              if (out_free) begin
                out_valid_q <= 1'b1;
                out_eob_q   <= 1'b1;
                out_run_q   <= '0;
                out_level_q <= '0;
              end
            end else begin
              run_q <= run_q + 1'b1;
            end
            // Trailing zero run is dropped: EOB implies it.
            if (is_last) begin
              state_q <= ST_EOB;
              run_q   <= '0;
            end else begin
              k_q     <= k_q + 6'd1;
              raddr_q <= rom_addr;
            end
          end
        end
        ST_EOB: begin
          if (out_valid_q && out_eob_q) begin
            if (out_ready) begin
              state_q <= ST_IDLE;
              rdy_q   <= 1'b1;
            end
          end else if (out_free) begin
            out_valid_q <= 1'b1;
            out_eob_q   <= 1'b1;
            out_run_q   <= '0;
            out_level_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdy       = rdy_q;
  assign raddr     = raddr_q;
  assign out_valid = out_valid_q;
  assign out_run   = out_run_q;
  assign out_level = out_level_q;
  assign out_eob   = out_eob_q;

endmodule
`default_nettype wire

// File: tb/tb_zigzag_rle.sv
`default_nettype none
// ============================================================================
// Module   : tb_zigzag_rle
// Purpose  : Self-checking bench for zigzag_rle against a token-stream model
//            built from the zigzag/run-length rules (RLE_DC_DIFF_EN aware).
// Revision : 1.0  initial release
// ============================================================================
module tb_zigzag_rle;

  localparam int CW = 16;
  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic          rdy;
  logic [5:0]    raddr;
  logic [CW-1:0] rq;
  logic          dc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_run;
  logic [CW-1:0] out_level;
  logic          out_eob;

  always #5 clk = ~clk;

  zigzag_rle #(.CW(CW), .RW(RW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .rdy       (rdy),
    .raddr     (raddr),
    .rq        (rq),
    .dc_clr    (dc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_level (out_level),
    .out_eob   (out_eob)
  );

  logic [15:0] mem [64];
  always @(posedge clk) rq <= mem[raddr];

  int          zz [64];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic [15:0] pred;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tok(input bit e, input int r, input logic [15:0] l);
    logic [5:0] r6;
    r6 = r[5:0];
    return {9'd0, e, r6, l};
  endfunction

  // Zigzag = walk anti-diagonals, alternating direction.
  task automatic build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
      end
    end
  endtask

  task automatic model(input bit clr);
    int run = 0;
    logic [15:0] c;
    exp_q.delete();
    if (clr) pred = 16'd0;
    for (int i = 0; i < 64; i++) begin
      c = mem[zz[i]];
      if (i == 0) begin
`ifdef RLE_DC_DIFF_EN
        exp_q.push_back(tok(1'b0, 0, c - pred));
        pred = c;
`else
        exp_q.push_back(tok(1'b0, 0, c));
`endif
      end else if (c == 16'd0) begin
        run++;
      end else begin
        exp_q.push_back(tok(1'b0, run, c));
        run = 0;
      end
    end
    exp_q.push_back(tok(1'b1, 0, 16'd0));
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 64; a++) mem[a] = 16'd0;
  endtask

  task automatic run_block(input string name, input bit rnd, input bit clr, output int lat);
    bit          pstall = 1'b0;
    bit          done   = 1'b0;
    int          first  = -1;
    logic [31:0] ptok   = 32'd0;
    logic [31:0] cur;
    model(clr);
    got_q.delete();
    lat = -1;
    en = 1'b1; dc_clr = clr;
    @(posedge clk); #1;
    en = 1'b0; dc_clr = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid && first < 0) first = i;
      cur = tok(out_eob, int'(out_run), out_level);
      if (pstall) begin
        chk({name, "_stall_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_stall_fields"}, cur, ptok);
      end
      pstall = out_valid && !out_ready;
      ptok   = cur;
      if (out_valid && out_ready) begin
        got_q.push_back(cur);
        if (out_eob) begin done = 1'b1; lat = i + 1; end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk({name, "_eob_seen"}, 32'(done), 32'd1);
    chk({name, "_first_lat"}, first, 32'd2);
    chk({name, "_rdy_after"}, 32'(rdy), 32'd1);
    chk({name, "_valid_after"}, 32'(out_valid), 32'd0);
    chk({name, "_ntok"}, got_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size(); j++)
      chk($sformatf("%s_tok%0d", name, j), (j < got_q.size()) ? got_q[j] : 32'hdead_beef, exp_q[j]);
  endtask

  initial begin
    int lat;
    build_zz();
    clear_mem();
    reset_n = 1'b0; en = 1'b0; dc_clr = 1'b0; out_ready = 1'b1; pred = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_fields", tok(out_eob, int'(out_run), out_level), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // DC-only block: minimum latency.
    clear_mem(); mem[zz[0]] = 16'd100;
    run_block("dc_only", 1'b0, 1'b0, lat);
    chk("dc_only_lat", lat, 32'd66);
    chk("dc_only_tok0", (got_q.size() > 0) ? got_q[0] : 32'hdead_beef, tok(1'b0, 0, 16'd100));

    // Sparse block with a nonzero last coefficient.
    clear_mem();
    mem[zz[0]] = 16'd25; mem[zz[1]] = 16'hFFFD; mem[zz[5]] = 16'd7; mem[zz[63]] = 16'd1;
    run_block("sparse", 1'b0, 1'b0, lat);
    chk("sparse_lat", lat, 32'd67);
    chk("sparse_tok2", (got_q.size() > 2) ? got_q[2] : 32'hdead_beef, tok(1'b0, 3, 16'd7));
    chk("sparse_tok3", (got_q.size() > 3) ? got_q[3] : 32'hdead_beef, tok(1'b0, 57, 16'd1));

    // All-zero block.
    clear_mem();
    run_block("zero", 1'b0, 1'b0, lat);
    chk("zero_lat", lat, 32'd66);

    // Maximum run of 62.
    clear_mem(); mem[zz[63]] = 16'h8000;
    run_block("maxrun", 1'b0, 1'b0, lat);
    chk("maxrun_tok1", (got_q.size() > 1) ? got_q[1] : 32'hdead_beef, tok(1'b0, 62, 16'h8000));

    // Random blocks, alternating free-running and random back-pressure.
    for (int r = 0; r < 8; r++) begin
      int dens = (r < 6) ? 15 + r * 15 : 100;
      for (int a = 0; a < 64; a++)
        mem[a] = ($urandom_range(0, 99) < dens) ? 16'($urandom) : 16'd0;
      run_block($sformatf("rand%0d", r), (r % 2 == 1) || (r >= 6), 1'b0, lat);
    end

    // Asynchronous reset in the middle of the scan (k = 30).
    for (int a = 0; a < 64; a++) mem[a] = 16'($urandom_range(1, 500));
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (31) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_rdy", 32'(rdy), 32'd1);
    pred = 16'd0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_block("after_rst", 1'b0, 1'b0, lat);

    // DC sequence 50, 60, then cleared predictor with 40.
    clear_mem(); mem[zz[0]] = 16'd50;
    run_block("dc50", 1'b0, 1'b0, lat);
    clear_mem(); mem[zz[0]] = 16'd60;
    run_block("dc60", 1'b1, 1'b0, lat);
`ifdef RLE_DC_DIFF_EN
    chk("dc60_level", (got_q.size() > 0) ? got_q[0] : 32'hdead_beef, tok(1'b0, 0, 16'd10));
`else
    chk("dc60_level", (got_q.size() > 0) ? got_q[0] : 32'hdead_beef, tok(1'b0, 0, 16'd60));
`endif
    clear_mem(); mem[zz[0]] = 16'd40;
    run_block("dc40", 1'b0, 1'b1, lat);
    chk("dc40_level", (got_q.size() > 0) ? got_q[0] : 32'hdead_beef, tok(1'b0, 0, 16'd40));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
